soml_bit_mapper: RTL and testbench
==================================

SOML_BIT_MAPPER -- requirements
Module: soml_bit_mapper

Interface
REQ-001 SHALL have parameter N, default 32: signed width of each index input.
REQ-002 SHALL have parameter M_BITS, default 2: Gray bits per I/Q index; valid index range 1..2^M_BITS.
REQ-003 SHALL have parameter Q_BITS, default 4: antenna-index bits; valid q_min range 1..2^Q_BITS.
REQ-004 SHALL have parameter OUT_W, default 4: bits per output beat; frame width F = 4*M_BITS+Q_BITS must be a multiple of OUT_W, else elaboration fails.
REQ-005 SHALL have parameter DEPTH, default 4: frame FIFO depth, power of two, >=2.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: in_valid in 1; in_ready out 1; m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2 in N signed each; q_min in Q_BITS+1 unsigned.
REQ-008 SHALL have ports: flush in 1, synchronous abort; out_data out OUT_W; out_valid out 1; out_ready in 1; out_last out 1, final beat of a frame.
REQ-009 SHALL have ports: err_sticky out 1; err_cnt out 16; frame_cnt out 16.

Function
REQ-010 Index map SHALL be Gray(k-1) = (k-1) XOR ((k-1)>>1) for k in 1..2^M_BITS; defaults 1->00, 2->01, 3->11, 4->10.
REQ-011 Out-of-range index (<1 or >2^M_BITS, negatives included) SHALL map to all-zero bits and flag the frame erroneous.
REQ-012 b2 SHALL be q_min-1 truncated to Q_BITS; q_min of 0 or >2^Q_BITS SHALL map to 0 and flag the frame erroneous.
REQ-013 Frame SHALL be {Gray(m_Imin_1), Gray(m_Qmin_1), Gray(m_Imin_2), Gray(m_Qmin_2), b2}, F bits, MSB first.
REQ-014 Frame acceptance SHALL occur on a clock edge with in_valid && in_ready && !flush; the mapped frame is written to the FIFO on that edge.
REQ-015 in_ready SHALL equal !FIFO_full, registered; no write when full.
REQ-016 Serializer SHALL load the FIFO head when idle, or on the edge completing the last-beat handshake, if the FIFO is non-empty; back-to-back frames SHALL have no bubble.
REQ-017 Latency: frame accepted at edge E0 into empty FIFO with idle serializer SHALL present beat 0 with out_valid=1 after edge E1.
REQ-018 Beats SHALL be F/OUT_W per frame, MSB slice first; out_last=1 only on the final beat.
REQ-019 out_data/out_last SHALL hold stable while out_valid && !out_ready; beat advances only on out_valid && out_ready.
REQ-020 out_valid SHALL not depend combinationally on out_ready.
REQ-021 FIFO read and write on the same edge SHALL both take effect; occupancy unchanged.
REQ-022 err_cnt SHALL increment by one per accepted erroneous frame, saturating at 0xFFFF; err_sticky SHALL set on the first one and clear only by reset.
REQ-023 frame_cnt SHALL increment on each last-beat handshake, wrapping 0xFFFF->0.
REQ-024 flush SHALL, on its edge, empty the FIFO, abort the serializer (out_valid=0 after the edge), block acceptance, and leave counters and err_sticky unchanged.

Reset
REQ-025 rst_n low SHALL asynchronously force: FIFO empty, serializer idle, out_valid=0, out_last=0, out_data=0, in_ready=0, err_sticky=0, err_cnt=0, frame_cnt=0.
REQ-026 in_ready SHALL rise after the first clk edge following rst_n deassertion.
REQ-027 Reset mid-frame SHALL discard all buffered and partially sent frames; no beat follows reset until a new frame is accepted.

Verification
REQ-028 Indices (1,2,3,4), q_min=16, out_ready=1 -> beats 0x1, 0xE, 0xF; out_last on third beat; frame_cnt=1.
REQ-029 Indices (5,1,1,1), q_min=0 -> beats 0x0, 0x0, 0x0; err_cnt=1; err_sticky=1.
REQ-030 out_ready=0, five frames offered -> four accepted, in_ready=0; beat 0 held stable; releasing out_ready drains 12 beats in order, no bubbles.
REQ-031 Two back-to-back frames, out_ready=1 -> 6 consecutive valid beats, out_last on beats 3 and 6.
REQ-032 flush asserted during beat 1 with 2 frames queued -> out_valid=0 next cycle; FIFO empty; frame_cnt and err_cnt unchanged.
REQ-033 rst_n pulsed low mid-frame -> all outputs at reset values immediately; err_cnt=0; no stale beats afterward.

Source files
------------

// File: rtl/soml_bit_mapper.sv
// Maps SOML antenna/constellation indices to a Gray-coded bit frame,
// buffers frames in a small FIFO and streams them out OUT_W bits per beat.
// A frame stays in the FIFO while it is being serialized, so DEPTH counts
// the frame in flight as well as the ones waiting behind it.
module soml_bit_mapper #(
  parameter int unsigned N      = 32,
  parameter int unsigned M_BITS = 2,
  parameter int unsigned Q_BITS = 4,
  parameter int unsigned OUT_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] m_Imin_1,
  input  logic signed [N-1:0] m_Qmin_1,
  input  logic signed [N-1:0] m_Imin_2,
  input  logic signed [N-1:0] m_Qmin_2,
  input  logic [Q_BITS:0]     q_min,
  input  logic                flush,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                err_sticky,
  output logic [15:0]         err_cnt,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned F       = 4 * M_BITS + Q_BITS;
  localparam int unsigned BEATS   = F / OUT_W;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned QW      = Q_BITS + 1;
  localparam int unsigned IDX_MAX = 2 ** M_BITS;
  localparam int unsigned QM_MAX  = 2 ** Q_BITS;

  // Reject parameter sets the datapath cannot represent.
  if ((F % OUT_W) != 0) begin : g_bad_out_w
    $error("soml_bit_mapper: frame width must be a multiple of OUT_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("soml_bit_mapper: DEPTH must be a power of two >= 2");
  end

  // Returns {error, gray_bits}; out-of-range indices give zero bits.
  function automatic logic [M_BITS:0] map_idx(input logic signed [N-1:0] k);
    logic [M_BITS-1:0] km1;
    logic              ok;
    ok  = !k[N-1] && (k != '0) && (unsigned'(k) <= N'(IDX_MAX));
    km1 = M_BITS'(unsigned'(k) - N'(1));
    map_idx = ok ? {1'b0, km1 ^ (km1 >> 1)} : {1'b1, {M_BITS{1'b0}}};
  endfunction

  logic [M_BITS:0] mi1, mq1, mi2, mq2;
  logic            q_ok;
  logic [Q_BITS-1:0] b2;
  logic [F-1:0]    in_frame;
  logic            in_err;

  // Input mapping: Gray-coded indices plus antenna bits, with error flag.
  always_comb begin
    mi1      = map_idx(m_Imin_1);
    mq1      = map_idx(m_Qmin_1);
    mi2      = map_idx(m_Imin_2);
    mq2      = map_idx(m_Qmin_2);
    q_ok     = (q_min != '0) && (q_min <= QW'(QM_MAX));
    b2       = q_ok ? Q_BITS'(q_min - QW'(1)) : '0;
    in_frame = {mi1[M_BITS-1:0], mq1[M_BITS-1:0], mi2[M_BITS-1:0],
                mq2[M_BITS-1:0], b2};
    in_err   = mi1[M_BITS] | mq1[M_BITS] | mi2[M_BITS] | mq2[M_BITS] | !q_ok;
  end

  logic [F-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, rd_next;
  logic [PW-1:0]    count, count_n;
  logic [F-1:0]     shreg;
  logic [BCW-1:0]   beat_cnt;
  logic             accept, beat_hs, last_hs, pop, load;
  logic [F-1:0]     load_frame;

  // Handshakes, FIFO pointer updates and serializer load selection.
  always_comb begin
    count      = wr_ptr - rd_ptr;
    accept     = in_valid && in_ready && !flush;
    beat_hs    = out_valid && out_ready;
    last_hs    = beat_hs && out_last;
    pop        = last_hs && !flush;
    rd_next    = rd_ptr + PW'(1);
    load       = 1'b0;
    load_frame = mem[rd_ptr[AW-1:0]];
    if (!flush) begin
      if (!out_valid && (count != '0)) begin
        load = 1'b1;
      end else if (last_hs && (count > PW'(1))) begin
        load       = 1'b1;
        load_frame = mem[rd_next[AW-1:0]];
      end else if (last_hs && accept) begin
        // The only remaining frame arrives on this very edge: bypass the FIFO.
        load       = 1'b1;
        load_frame = in_frame;
      end
    end
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      wr_ptr_n = accept ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_n = pop ? rd_next : rd_ptr;
    end
    count_n = wr_ptr_n - rd_ptr_n;
  end

  // FIFO storage (no reset needed; occupancy is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= in_frame;
    end
  end

  // FIFO pointers and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      in_ready <= (count_n != PW'(DEPTH));
    end
  end

  // Serializer: load a frame, shift out MSB slice first, drop valid after last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      shreg     <= load_frame;
      beat_cnt  <= '0;
      out_valid <= 1'b1;
      out_last  <= (BEATS == 1);
    end else if (beat_hs) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        shreg    <= shreg << OUT_W;
        beat_cnt <= beat_cnt + BCW'(1);
        out_last <= (beat_cnt == BCW'(BEATS - 2));
      end
    end
  end

  assign out_data = shreg[F-1 -: OUT_W];

  // Status counters: saturating error count, wrapping frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      if (accept && in_err) begin
        err_sticky <= 1'b1;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
      if (pop) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_soml_bit_mapper.sv
// Randomized bench for soml_bit_mapper with a behavioural frame/beat model.
module tb_soml_bit_mapper;

  localparam int N      = 32;
  localparam int M_BITS = 2;
  localparam int Q_BITS = 4;
  localparam int OUT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int F      = 4 * M_BITS + Q_BITS;
  localparam int BEATS  = F / OUT_W;
  localparam int QW     = Q_BITS + 1;

  typedef struct {
    int i1; int q1; int i2; int q2; int qm;
  } frame_t;

  typedef struct {
    int data; bit last;
  } beat_t;

  logic                clk, rst_n, in_valid, in_ready, flush;
  logic signed [N-1:0] m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2;
  logic [Q_BITS:0]     q_min;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid, out_ready, out_last, err_sticky;
  logic [15:0]         err_cnt, frame_cnt;

  soml_bit_mapper #(.N(N), .M_BITS(M_BITS), .Q_BITS(Q_BITS), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m_Imin_1(m_Imin_1), .m_Qmin_1(m_Qmin_1), .m_Imin_2(m_Imin_2), .m_Qmin_2(m_Qmin_2),
    .q_min(q_min), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks, n_errors;
  beat_t  expq[$];
  frame_t txq[$];
  int     got_data[$];
  bit     got_last[$];
  time    hs_t[$];
  time    acc_tq[$];
  time    first_valid_t;
  bit     first_valid_seen;
  int     m_err_cnt, m_frame_cnt;
  bit     m_err_sticky;

  // Reference: Gray code of k-1 for an in-range index, else zero and bad.
  function automatic int gray_of(input int k, output bit bad);
    if (k < 1 || k > (1 << M_BITS)) begin
      bad = 1'b1;
      return 0;
    end
    bad = 1'b0;
    return (k - 1) ^ ((k - 1) >> 1);
  endfunction

  // Reference: the whole frame as an integer, first index most significant.
  function automatic int model_frame(input frame_t f, output bit bad);
    bit b1, b2, b3, b4, b5;
    int g1, g2, g3, g4, qb, w;
    g1 = gray_of(f.i1, b1);
    g2 = gray_of(f.q1, b2);
    g3 = gray_of(f.i2, b3);
    g4 = gray_of(f.q2, b4);
    if (f.qm < 1 || f.qm > (1 << Q_BITS)) begin
      b5 = 1'b1; qb = 0;
    end else begin
      b5 = 1'b0; qb = f.qm - 1;
    end
    bad = b1 | b2 | b3 | b4 | b5;
    w = 1 << M_BITS;
    return (((g1 * w + g2) * w + g3) * w + g4) * (1 << Q_BITS) + qb;
  endfunction

  function automatic frame_t rand_valid_frame();
    frame_t f;
    f.i1 = int'($urandom_range(1, 4));
    f.q1 = int'($urandom_range(1, 4));
    f.i2 = int'($urandom_range(1, 4));
    f.q2 = int'($urandom_range(1, 4));
    f.qm = int'($urandom_range(1, 16));
    return f;
  endfunction

  function automatic int rand_idx();
    if ($urandom_range(9) == 0) return int'($urandom);
    return int'($urandom_range(7)) - 1;
  endfunction

  // Offer one frame; on acceptance record the expected beats and error state.
  task automatic send_frame(input frame_t f, input int max_wait, output bit ok);
    bit    rdy, bad;
    int    waited, fr;
    beat_t e;
    ok = 1'b0;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    m_Imin_1 = f.i1; m_Qmin_1 = f.q1; m_Imin_2 = f.i2; m_Qmin_2 = f.q2;
    q_min = QW'(f.qm);
    rdy = in_ready;
    while (!rdy && waited < max_wait) begin
      @(negedge clk);
      waited++;
      rdy = in_ready;
    end
    if (rdy) begin
      @(posedge clk);
      ok = 1'b1;
      acc_tq.push_back($time);
      fr = model_frame(f, bad);
      for (int b = 0; b < BEATS; b++) begin
        e.data = (fr >> (F - OUT_W * (b + 1))) & ((1 << OUT_W) - 1);
        e.last = (b == BEATS - 1);
        expq.push_back(e);
      end
      if (bad) begin
        m_err_sticky = 1'b1;
        if (m_err_cnt < 65535) m_err_cnt++;
      end
    end
  endtask

  // Send everything in txq while draining and checking all expected beats.
  task automatic run_stream(input int rdy_pct);
    int n_exp;
    n_exp = expq.size() + txq.size() * BEATS;
    got_data.delete(); got_last.delete(); hs_t.delete(); acc_tq.delete();
    first_valid_seen = 1'b0;
    fork
      begin
        bit ok;
        frame_t f;
        while (txq.size() > 0) begin
          f = txq.pop_front();
          send_frame(f, 500, ok);
          n_checks++;
          if (!ok) begin
            n_errors++;
            $display("FAIL stream_accept: frame not accepted, in_ready=%0b", in_ready);
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int got, guard;
        bit prev_stall, prev_l;
        logic [OUT_W-1:0] prev_d;
        beat_t e;
        got = 0; guard = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        while (got < n_exp && guard < 4000) begin
          @(negedge clk);
          guard++;
          if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
              n_errors++;
              $display("FAIL hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                       out_valid, out_data, out_last, prev_d, prev_l);
            end
          end
          if (out_valid === 1'b1 && !first_valid_seen) begin
            first_valid_seen = 1'b1;
            first_valid_t = $time;
          end
          out_ready = (int'($urandom_range(99)) < rdy_pct);
          if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (expq.size() == 0) begin
              n_errors++;
              $display("FAIL beat: unexpected beat d=%h l=%b", out_data, out_last);
            end else begin
              e = expq.pop_front();
              if (out_data !== OUT_W'(e.data) || out_last !== e.last) begin
                n_errors++;
                $display("FAIL beat %0d: got d=%h l=%b, want d=%h l=%b",
                         got, out_data, out_last, OUT_W'(e.data), e.last);
              end
              if (e.last) m_frame_cnt = (m_frame_cnt + 1) & 16'hFFFF;
            end
            got_data.push_back(int'(out_data));
            got_last.push_back(out_last);
            hs_t.push_back($time);
            got++;
          end
          prev_stall = (out_valid === 1'b1) && !out_ready;
          prev_d = out_data;
          prev_l = out_last;
        end
        n_checks++;
        if (got < n_exp) begin
          n_errors++;
          $display("FAIL stream_timeout: got %0d beats, want %0d", got, n_exp);
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (frame_cnt !== 16'(m_frame_cnt) || err_cnt !== 16'(m_err_cnt) || err_sticky !== m_err_sticky) begin
      n_errors++;
      $display("FAIL %s counters: got frame=%0d err=%0d sticky=%b, want frame=%0d err=%0d sticky=%b",
               tag, frame_cnt, err_cnt, err_sticky, m_frame_cnt, m_err_cnt, m_err_sticky);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s idle: out_valid got %b want 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 ||
        err_sticky !== 1'b0 || err_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_values: v=%b l=%b d=%h rdy=%b st=%b ec=%0d fc=%0d, want all 0",
               out_valid, out_last, out_data, in_ready, err_sticky, err_cnt, frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready got %b want 0 before first edge", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    frame_t f;
    int exp_a[3];
    exp_a = '{1, 14, 15};
    f = '{i1: 1, q1: 2, i2: 3, q2: 4, qm: 16};
    txq.push_back(f);
    run_stream(100);
    n_checks++;
    if (got_data.size() < 3) begin
      n_errors++;
      $display("FAIL vec_a_count: got %0d beats want 3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (got_data[i] !== exp_a[i] || got_last[i] !== (i == 2)) begin
          n_errors++;
          $display("FAIL vec_a beat %0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_a[i], i == 2);
        end
      end
    end
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL vec_a_frame_cnt: got %0d want 1", frame_cnt);
    end
    f = '{i1: 5, q1: 1, i2: 1, q2: 1, qm: 0};
    txq.push_back(f);
    run_stream(100);
    n_checks++;
    if (got_data.size() < 3 || got_data[0] !== 0 || got_data[1] !== 0 || got_data[2] !== 0) begin
      n_errors++;
      $display("FAIL vec_b beats: got size %0d, want three zero beats", got_data.size());
    end
    n_checks++;
    if (err_cnt !== 16'd1 || err_sticky !== 1'b1) begin
      n_errors++;
      $display("FAIL vec_b err: got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky);
    end
    check_counters("vectors");
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted;
    beat_t e0;
    out_ready = 1'b0;
    accepted = 0;
    acc_tq.delete();
    for (int i = 0; i < 5; i++) begin
      send_frame(rand_valid_frame(), (i < 4) ? 20 : 8, ok);
      if (ok) accepted++;
    end
    n_checks++;
    if (accepted !== 4) begin
      n_errors++;
      $display("FAIL bp_accepted: got %0d want 4", accepted);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    e0 = expq[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(e0.data) || out_last !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=0", out_valid, out_data, out_last, OUT_W'(e0.data));
      end
    end
    run_stream(100);
    n_checks++;
    if (hs_t.size() !== 12) begin
      n_errors++;
      $display("FAIL bp_drain: got %0d beats want 12", hs_t.size());
    end
    for (int i = 1; i < hs_t.size(); i++) begin
      n_checks++;
      if (hs_t[i] - hs_t[i-1] !== 10) begin
        n_errors++;
        $display("FAIL bp_bubble at beat %0d: gap %0t want 10", i, hs_t[i] - hs_t[i-1]);
      end
    end
    check_counters("backpressure");
  endtask

  task automatic test_back_to_back();
    txq.push_back(rand_valid_frame());
    txq.push_back(rand_valid_frame());
    run_stream(100);
    n_checks++;
    if (hs_t.size() !== 6) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d beats want 6", hs_t.size());
    end
    for (int i = 1; i < hs_t.size(); i++) begin
      n_checks++;
      if (hs_t[i] - hs_t[i-1] !== 10) begin
        n_errors++;
        $display("FAIL b2b_bubble at beat %0d: gap %0t want 10", i, hs_t[i] - hs_t[i-1]);
      end
    end
    n_checks++;
    if (!first_valid_seen || acc_tq.size() == 0 || first_valid_t - acc_tq[0] !== 15) begin
      n_errors++;
      $display("FAIL b2b_latency: first valid %0t after accept, want 15", first_valid_t - acc_tq[0]);
    end
    check_counters("back_to_back");
  endtask

  task automatic test_flush();
    bit ok;
    frame_t f;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(rand_valid_frame(), 20, ok);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== OUT_W'(expq[1].data)) begin
      n_errors++;
      $display("FAIL flush_beat1: got v=%b d=%h want v=1 d=%h", out_valid, out_data, OUT_W'(expq[1].data));
    end
    out_ready = 1'b0;
    flush = 1'b1;
    f = rand_valid_frame();
    f.i1 = 7;
    in_valid = 1'b1;
    m_Imin_1 = f.i1; m_Qmin_1 = f.q1; m_Imin_2 = f.i2; m_Qmin_2 = f.q2;
    q_min = QW'(f.qm);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: got v=%b l=%b rdy=%b want 0/0/1", out_valid, out_last, in_ready);
    end
    check_counters("flush");
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_stale: out_valid got %b want 0 at cycle %0d", out_valid, i);
      end
    end
    check_counters("post_flush");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    out_ready = 1'b0;
    send_frame(rand_valid_frame(), 20, ok);
    send_frame(rand_valid_frame(), 20, ok);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 ||
        err_sticky !== 1'b0 || err_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL midreset_values: v=%b l=%b d=%h rdy=%b st=%b ec=%0d fc=%0d, want all 0",
               out_valid, out_last, out_data, in_ready, err_sticky, err_cnt, frame_cnt);
    end
    expq.delete();
    m_err_cnt = 0; m_frame_cnt = 0; m_err_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_stale: out_valid got %b want 0 at cycle %0d", out_valid, i);
      end
    end
    check_counters("midreset");
  endtask

  task automatic test_random();
    frame_t f;
    for (int i = 0; i < 30; i++) begin
      f.i1 = rand_idx(); f.q1 = rand_idx(); f.i2 = rand_idx(); f.q2 = rand_idx();
      f.qm = int'($urandom_range(0, 20));
      txq.push_back(f);
    end
    run_stream(60);
    check_counters("random");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_err_cnt = 0; m_frame_cnt = 0; m_err_sticky = 1'b0;
    first_valid_t = 0; first_valid_seen = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    m_Imin_1 = '0; m_Qmin_1 = '0; m_Imin_2 = '0; m_Qmin_2 = '0; q_min = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
